// File: rtl/sdio_pkg.sv
// Shared types, constants and the CRC7 step function for the SDIO command path.
// The command transmitter uses this package too.
package sdio_pkg;

    localparam int RSP_LEN = 48;
    localparam int CRC_LEN = 7;
    localparam logic [CRC_LEN-1:0] CRC7_POLY = 7'h09;

    // Frame bits 47..8 are protected by the CRC7.
    localparam int CRC_SPAN = RSP_LEN - 8;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_START,
        SHIFT,
        CHECK
    } rsp_state_t;

    // One serial step of x^7 + x^3 + 1, MSB-first.
    function automatic logic [CRC_LEN-1:0] crc7_next(input logic [CRC_LEN-1:0] crc,
                                                     input logic din);
        logic fb;
        fb = din ^ crc[CRC_LEN-1];
        return {crc[CRC_LEN-2:0], 1'b0} ^ (fb ? CRC7_POLY : '0);
    endfunction

endpackage

// File: rtl/sdio_rsp_receiver_if.sv
// Handshake and result bundle between the CMD-line sampler/AXI slave and the
// response receiver.
interface sdio_rsp_receiver_if;
    import sdio_pkg::*;

    logic               bit_stb;
    logic               sd_cmd_in;
    logic               rsp_start;
    logic               crc_check_en;
    logic               busy;
    logic               rsp_done;
    logic [RSP_LEN-1:0] cmd_reg;
    logic               cmd_valid;
    logic               crc_error;
    logic               timeout_error;

    modport master (
        output bit_stb,
        output sd_cmd_in,
        output rsp_start,
        output crc_check_en,
        input  busy,
        input  rsp_done,
        input  cmd_reg,
        input  cmd_valid,
        input  crc_error,
        input  timeout_error
    );

    modport slave (
        input  bit_stb,
        input  sd_cmd_in,
        input  rsp_start,
        input  crc_check_en,
        output busy,
        output rsp_done,
        output cmd_reg,
        output cmd_valid,
        output crc_error,
        output timeout_error
    );

endinterface

// File: rtl/sdio_crc7_serial.sv
// Bit-serial CRC7 accumulator; clear wins over enable.
module sdio_crc7_serial
    import sdio_pkg::*;
(
    input  logic               clk,
    input  logic               srst,
    input  logic               clear,
    input  logic               enable,
    input  logic               data_in,
    output logic [CRC_LEN-1:0] crc_out
);

    logic [CRC_LEN-1:0] crc_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            crc_reg <= '0;
        end else if (clear) begin
            crc_reg <= '0;
        end else if (enable) begin
            crc_reg <= crc7_next(crc_reg, data_in);
        end
    end

    assign crc_out = crc_reg;

endmodule

// File: rtl/sdio_rsp_receiver.sv
// Deserialises a 48-bit SD response from the sampled CMD line, checks framing
// and CRC7, and enforces the NCR start-bit timeout.
module sdio_rsp_receiver
    import sdio_pkg::*;
#(
    parameter int TIMEOUT_BITS = 64,
    parameter int CNT_W        = 7
) (
    input  logic          axi_clk,
    input  logic          axi_reset,
    sdio_rsp_receiver_if.slave rsp
);

    localparam int BIT_W = $clog2(RSP_LEN + 1);

    rsp_state_t         state_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic [BIT_W-1:0]   bit_cnt_reg;
    logic [RSP_LEN-1:0] shift_reg_reg;
    logic               check_en_reg;
    logic               busy_reg;
    logic               rsp_done_reg;
    logic [RSP_LEN-1:0] cmd_reg_reg;
    logic               cmd_valid_reg;
    logic               crc_error_reg;
    logic               timeout_error_reg;

    logic               crc_clear;
    logic               crc_en;
    logic [CRC_LEN-1:0] crc_value;
    logic               frame_error;
    logic               start_accept;

    // A start arriving alongside rsp_done belongs to the finished response.
    assign start_accept = (state_reg == IDLE) && rsp.rsp_start && !rsp_done_reg;
    assign crc_clear    = start_accept;
    assign crc_en       = rsp.bit_stb &&
                          (((state_reg == WAIT_START) && !rsp.sd_cmd_in) ||
                           ((state_reg == SHIFT) && (bit_cnt_reg < BIT_W'(CRC_SPAN))));

    sdio_crc7_serial u_crc (
        .clk     (axi_clk),
        .srst    (axi_reset),
        .clear   (crc_clear),
        .enable  (crc_en),
        .data_in (rsp.sd_cmd_in),
        .crc_out (crc_value)
    );

    always_comb begin
        frame_error = shift_reg_reg[RSP_LEN-2] || !shift_reg_reg[0] ||
                      (check_en_reg && (shift_reg_reg[CRC_LEN:1] != crc_value));
    end

    always_ff @(posedge axi_clk) begin
        if (axi_reset) begin
            state_reg         <= IDLE;
            cnt_reg           <= '0;
            bit_cnt_reg       <= '0;
            shift_reg_reg     <= '0;
            check_en_reg      <= 1'b0;
            busy_reg          <= 1'b0;
            rsp_done_reg      <= 1'b0;
            cmd_reg_reg       <= '0;
            cmd_valid_reg     <= 1'b0;
            crc_error_reg     <= 1'b0;
            timeout_error_reg <= 1'b0;
        end else begin
            rsp_done_reg  <= 1'b0;
            cmd_valid_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start_accept) begin
                        state_reg         <= WAIT_START;
                        crc_error_reg     <= 1'b0;
                        timeout_error_reg <= 1'b0;
                        check_en_reg      <= rsp.crc_check_en;
                        cnt_reg           <= '0;
                        bit_cnt_reg       <= '0;
                        shift_reg_reg     <= '0;
                        busy_reg          <= 1'b1;
                    end
                end
                WAIT_START: begin
                    if (rsp.bit_stb) begin
                        if (!rsp.sd_cmd_in) begin
                            shift_reg_reg <= {shift_reg_reg[RSP_LEN-2:0], 1'b0};
                            bit_cnt_reg   <= BIT_W'(1);
                            state_reg     <= SHIFT;
                        end else begin
                            cnt_reg <= cnt_reg + CNT_W'(1);
                            // This strobe brings the count to TIMEOUT_BITS.
                            if (cnt_reg == CNT_W'(TIMEOUT_BITS - 1)) begin
                                timeout_error_reg <= 1'b1;
                                rsp_done_reg      <= 1'b1;
                                busy_reg          <= 1'b0;
                                state_reg         <= IDLE;
                            end
                        end
                    end
                end
                SHIFT: begin
                    if (rsp.bit_stb) begin
                        shift_reg_reg <= {shift_reg_reg[RSP_LEN-2:0], rsp.sd_cmd_in};
                        bit_cnt_reg   <= bit_cnt_reg + BIT_W'(1);
                        if (bit_cnt_reg == BIT_W'(RSP_LEN - 1)) begin
                            state_reg <= CHECK;
                        end
                    end
                end
                CHECK: begin
                    cmd_reg_reg   <= shift_reg_reg;
                    cmd_valid_reg <= 1'b1;
                    rsp_done_reg  <= 1'b1;
                    crc_error_reg <= frame_error;
                    busy_reg      <= 1'b0;
                    state_reg     <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign rsp.busy          = busy_reg;
    assign rsp.rsp_done      = rsp_done_reg;
    assign rsp.cmd_reg       = cmd_reg_reg;
    assign rsp.cmd_valid     = cmd_valid_reg;
    assign rsp.crc_error     = crc_error_reg;
    assign rsp.timeout_error = timeout_error_reg;

endmodule

// File: tb/tb_sdio_rsp_receiver.sv
// Directed bench for the SDIO response receiver: stimulus pushes expected
// results, a negedge monitor pops and compares on every rsp_done.
module tb_sdio_rsp_receiver;

    logic axi_clk = 1'b0;
    logic axi_reset;

    always #5 axi_clk = ~axi_clk;

    sdio_rsp_receiver_if rsp_if ();

    sdio_rsp_receiver #(
        .TIMEOUT_BITS (64),
        .CNT_W        (7)
    ) dut (
        .axi_clk   (axi_clk),
        .axi_reset (axi_reset),
        .rsp       (rsp_if)
    );

    typedef struct {
        logic        is_frame;
        logic [47:0] cmd;
        logic        crc_err;
        logic        to_err;
    } exp_t;

    exp_t        exp_q[$];
    int          checks   = 0;
    int          errors   = 0;
    int          cyc      = 0;
    int          end_cyc  = 0;
    int          done_cnt = 0;
    logic [47:0] last_cmd = 48'h0;

    always @(posedge axi_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, expv);
        end
    endtask

    task automatic tick();
        @(posedge axi_clk);
        #1;
    endtask

    // Monitor / scoreboard
    always @(negedge axi_clk) begin
        if (axi_reset === 1'b0) begin
            if (rsp_if.cmd_valid === 1'b1)
                chk("valid_has_done", 48'(rsp_if.rsp_done), 48'd1);
            if (rsp_if.rsp_done === 1'b1) begin
                exp_t e;
                done_cnt++;
                $display("done %0d cmd_valid=%b cmd_reg=%h crc_error=%b timeout_error=%b",
                         done_cnt, rsp_if.cmd_valid, rsp_if.cmd_reg,
                         rsp_if.crc_error, rsp_if.timeout_error);
                if (exp_q.size() == 0) begin
                    chk("unexpected_done_count", 48'(exp_q.size()), 48'd1);
                end else begin
                    e = exp_q.pop_front();
                    chk("cmd_valid", 48'(rsp_if.cmd_valid), 48'(e.is_frame));
                    chk("cmd_reg", rsp_if.cmd_reg, e.cmd);
                    chk("crc_error", 48'(rsp_if.crc_error), 48'(e.crc_err));
                    chk("timeout_error", 48'(rsp_if.timeout_error), 48'(e.to_err));
                    chk("busy_at_done", 48'(rsp_if.busy), 48'd0);
                    if (e.is_frame)
                        chk("latency", 48'(cyc - end_cyc), 48'd2);
                end
            end
        end
    end

    task automatic strobe(input logic v, input int gap);
        rsp_if.sd_cmd_in = v;
        rsp_if.bit_stb   = 1'b1;
        tick();
        rsp_if.bit_stb   = 1'b0;
        rsp_if.sd_cmd_in = 1'b1;
        rsp_if.rsp_start = 1'b0;
        rsp_if.crc_check_en = 1'b1;
        for (int g = 1; g < gap; g++) tick();
    endtask

    task automatic start_rsp(input logic chk_en);
        rsp_if.rsp_start    = 1'b1;
        rsp_if.crc_check_en = chk_en;
        tick();
        rsp_if.rsp_start    = 1'b0;
        chk("busy_after_start", 48'(rsp_if.busy), 48'd1);
        chk("crc_err_cleared", 48'(rsp_if.crc_error), 48'd0);
        chk("to_err_cleared", 48'(rsp_if.timeout_error), 48'd0);
    endtask

    // Sends idle-high strobes then the frame MSB first; abort_bit stops early,
    // poke_bit raises rsp_start (with check disabled) alongside that bit.
    task automatic send_frame(input logic [47:0] f, input int idle, input int gap,
                              input int poke_bit, input int abort_bit);
        for (int k = 0; k < idle; k++) strobe(1'b1, gap);
        for (int i = 47; i >= 0; i--) begin
            if (47 - i == abort_bit) return;
            if (47 - i == poke_bit) begin
                rsp_if.rsp_start    = 1'b1;
                rsp_if.crc_check_en = 1'b0;
            end
            if (i == 0) end_cyc = cyc;
            strobe(f[i], gap);
        end
    endtask

    task automatic wait_queue(input int limit);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < limit) begin
            tick();
            n++;
        end
        chk("pending_after_wait", 48'(exp_q.size()), 48'd0);
        exp_q.delete();
    endtask

    task automatic run_frame(input logic [47:0] f, input logic chk_en, input logic err,
                             input int idle, input int gap, input int poke_bit);
        exp_q.push_back('{is_frame: 1'b1, cmd: f, crc_err: err, to_err: 1'b0});
        last_cmd = f;
        start_rsp(chk_en);
        send_frame(f, idle, gap, poke_bit, -1);
        wait_queue(400);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int snap;
        axi_reset           = 1'b1;
        rsp_if.bit_stb      = 1'b0;
        rsp_if.sd_cmd_in    = 1'b1;
        rsp_if.rsp_start    = 1'b0;
        rsp_if.crc_check_en = 1'b1;
        repeat (3) tick();
        chk("rst_busy", 48'(rsp_if.busy), 48'd0);
        chk("rst_rsp_done", 48'(rsp_if.rsp_done), 48'd0);
        chk("rst_cmd_valid", 48'(rsp_if.cmd_valid), 48'd0);
        chk("rst_crc_error", 48'(rsp_if.crc_error), 48'd0);
        chk("rst_timeout_error", 48'(rsp_if.timeout_error), 48'd0);
        chk("rst_cmd_reg", rsp_if.cmd_reg, 48'h0);
        axi_reset = 1'b0;
        tick();

        // Good R7, bad CRC with/without check
        run_frame(48'h08_0000_01AA_13, 1'b1, 1'b0, 10, 4, -1);
        run_frame(48'h08_0000_01AA_15, 1'b1, 1'b1, 10, 4, -1);
        run_frame(48'h08_0000_01AA_15, 1'b0, 1'b0, 10, 4, -1);

        // Timeout after 64 high strobes; cmd_reg keeps the last frame
        exp_q.push_back('{is_frame: 1'b0, cmd: last_cmd, crc_err: 1'b0, to_err: 1'b1});
        start_rsp(1'b1);
        for (int k = 0; k < 63; k++) strobe(1'b1, 4);
        chk("no_early_timeout_busy", 48'(rsp_if.busy), 48'd1);
        strobe(1'b1, 4);
        wait_queue(50);
        chk("timeout_level_held", 48'(rsp_if.timeout_error), 48'd1);

        // Start bit on the 64th strobe is a start
        run_frame(48'h08_0000_01AA_13, 1'b1, 1'b0, 63, 4, -1);

        // Framing errors
        run_frame(48'h08_0000_01AA_12, 1'b1, 1'b1, 5, 4, -1);
        run_frame(48'h48_0000_01AA_87, 1'b1, 1'b1, 5, 4, -1);

        // rsp_start during SHIFT is ignored (check enable not relatched)
        run_frame(48'h08_0000_01AA_15, 1'b1, 1'b1, 4, 3, 20);

        // Reset after 20 bits aborts silently
        start_rsp(1'b1);
        send_frame(48'h08_0000_01AA_13, 6, 4, -1, 20);
        snap = done_cnt;
        axi_reset = 1'b1;
        tick();
        chk("abort_busy", 48'(rsp_if.busy), 48'd0);
        chk("abort_rsp_done", 48'(rsp_if.rsp_done), 48'd0);
        chk("abort_cmd_reg", rsp_if.cmd_reg, 48'h0);
        axi_reset = 1'b0;
        last_cmd  = 48'h0;
        repeat (60) tick();
        chk("abort_no_done", 48'(done_cnt), 48'(snap));

        // Fresh start, continuous strobes; rsp_start coincident with rsp_done ignored
        exp_q.push_back('{is_frame: 1'b1, cmd: 48'h08_0000_01AA_13, crc_err: 1'b0, to_err: 1'b0});
        last_cmd = 48'h08_0000_01AA_13;
        start_rsp(1'b1);
        send_frame(48'h08_0000_01AA_13, 3, 1, -1, -1);
        n = 0;
        while (rsp_if.rsp_done !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("done_for_restart", 48'(rsp_if.rsp_done), 48'd1);
        rsp_if.rsp_start = 1'b1;
        tick();
        rsp_if.rsp_start = 1'b0;
        chk("restart_ignored_busy", 48'(rsp_if.busy), 48'd0);
        wait_queue(20);

        // Another continuous frame with no idle strobes
        run_frame(48'h48_0000_01AA_87, 1'b1, 1'b1, 0, 1, -1);

        repeat (5) tick();
        chk("queue_empty", 48'(exp_q.size()), 48'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sdio_rsp_receiver.md
Name: sdio_rsp_receiver

Overview:
- Upstream neighbour of the SDIO AXI register slave.
- Deserialises the card's 48-bit response frame from the sampled CMD line.
- Checks start, transmission and end bits and the CRC7; enforces the NCR response timeout.
- Produces cmd_reg, cmd_valid, crc_error and timeout_error, which the AXI slave consumes directly.

Parameters:
- TIMEOUT_BITS, 64: number of CMD bit strobes to wait for the start bit before flagging a timeout (NCR limit).
- CNT_W, 7: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_BITS.

Ports:
- axi_clk  in  1  single clock for all logic.
- axi_reset  in  1  synchronous, active-high reset.
- bit_stb  in  1  one-cycle strobe marking a valid sample of sd_cmd_in (one per SD clock).
- sd_cmd_in  in  1  CMD line level, already synchronised to axi_clk.
- rsp_start  in  1  pulse: arm the receiver for one response.
- crc_check_en  in  1  sampled with rsp_start; 0 disables the CRC7 check (R3 responses).
- busy  out  1  high from an accepted rsp_start until rsp_done.
- rsp_done  out  1  one-cycle pulse on any termination (frame or timeout).
- cmd_reg  out  48  last received frame, bit 47 = first bit on the wire.
- cmd_valid  out  1  one-cycle pulse when a complete frame is in cmd_reg.
- crc_error  out  1  level; set on a bad frame; valid from rsp_done until the next accepted rsp_start.
- timeout_error  out  1  level; same lifetime as crc_error.

Behaviour:
- Clock and reset: single clock axi_clk. axi_reset is synchronous, active-high.
  - Reset values: all outputs 0, cmd_reg = 48'h0, state IDLE, counters 0.
  - Reset asserted mid-frame aborts it: no rsp_done, no cmd_valid.
- FSM states: IDLE, WAIT_START, SHIFT, CHECK.
- IDLE:
  - rsp_start goes to WAIT_START.
  - On that transition: clear crc_error and timeout_error, latch crc_check_en, zero the CRC and counters, set busy.
  - rsp_start while busy is ignored.
- WAIT_START:
  - Only strobed cycles count.
  - bit_stb with sd_cmd_in = 0: start bit. Shift it in, set bit count to 1, go to SHIFT.
  - bit_stb with sd_cmd_in = 1: increment the timeout counter.
  - When the counter reaches TIMEOUT_BITS:
    - Set timeout_error, pulse rsp_done, clear busy, go to IDLE.
    - cmd_reg keeps its old value; cmd_valid is not pulsed.
  - A start bit on the TIMEOUT_BITS-th strobe counts as a start, not a timeout.
- SHIFT:
  - Each bit_stb shifts sd_cmd_in into the LSB of a 48-bit shift register and increments the bit count.
  - Frame bits 47..8 (40 bits) feed a serial CRC7 (x^7+x^3+1, initial value 0).
  - On the 48th bit (end bit), go to CHECK.
  - Non-strobed cycles hold all state.
- CHECK (exactly one cycle; bit_stb is ignored):
  - Error if any of the following: bit46 != 0, bit0 != 1, or (latched check enable and frame[7:1] != computed CRC).
  - On the exit edge, all of these take effect together:
    - cmd_reg <= shift register.
    - cmd_valid pulses.
    - rsp_done pulses.
    - crc_error <= error.
    - busy <= 0; return to IDLE.
- Latency: cmd_valid is high in the 2nd cycle after the cycle carrying the end-bit strobe.
- cmd_valid pulses even when crc_error is set; the consumer qualifies it with the error flag.
- rsp_start arriving in the same cycle as rsp_done is ignored; it is accepted from the next cycle.
- Back-to-back strobes on consecutive cycles must be supported (bit_stb may be held high continuously).

Decomposition:
- Package sdio_pkg holds:
  - FSM state enum.
  - RSP_LEN = 48, CRC_LEN = 7, CRC7_POLY = 7'h09.
  - Function crc7_next(crc, bit).
- One sub-module, sdio_crc7_serial: bit-serial CRC7 with clear, enable, data_in and crc_out.
  - Reused later by the command transmitter.

Test Plan:
- R7 frame 48'h08_0000_01AA_13, bit_stb every 4 cycles, start after 10 idle-high strobes:
  - cmd_valid pulses once, 2 cycles after the end-bit strobe.
  - cmd_reg = 48'h080000_01AA13, crc_error = 0, timeout_error = 0, rsp_done coincident with cmd_valid.
- Same frame with CRC field flipped (48'h08_0000_01AA_15):
  - cmd_valid = 1, crc_error = 1.
  - Repeat with crc_check_en = 0: crc_error = 0.
- Timeout boundaries, with TIMEOUT_BITS = 64:
  - CMD held high for 64 strobes → timeout_error = 1, rsp_done pulse, cmd_valid never asserted, cmd_reg unchanged.
  - Start bit on strobe 64 instead → normal frame reception.
- End bit driven 0 (48'h08_0000_01AA_12) → crc_error = 1.
  - Transmission bit 1 (48'h48_0000_01AA_87) → crc_error = 1.
- Protocol edge cases:
  - rsp_start during SHIFT is ignored; the frame completes correctly.
  - axi_reset asserted after 20 bits → next cycle busy = 0, no rsp_done.
  - A fresh rsp_start then receives a full frame correctly.
  - bit_stb held high continuously → correct frame capture.
